// File: rtl/enemy_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module      : enemy_sprite_engine
// Description : Single-enemy sprite engine. Owns the enemy's health and life
//               cycle (IDLE / ALIVE / FLASH / EXPLODE), sequences the flash and
//               explosion animations on frame ticks and draws one of four
//               shapes around a live centre point with a one-cycle registered
//               pixel path (rgb + coverage flag).
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_sprite_engine #(
  parameter int SIZE           = 16,
  parameter int COORD_W        = 10,
  parameter int FLASH_FRAMES   = 4,
  parameter int EXPLODE_FRAMES = 8,
  parameter int HP_T0          = 1,
  parameter int HP_T1          = 4,
  parameter int HP_T2          = 3,
  parameter int HP_T3          = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spawn_i,
  input  logic [1:0]         spawn_type_i,
  input  logic               hit_i,
  input  logic               frame_tick_i,
  input  logic [COORD_W-1:0] x_mid_i,
  input  logic [COORD_W-1:0] y_mid_i,
  input  logic [COORD_W-1:0] hcount_i,
  input  logic [COORD_W-1:0] vcount_i,
  output logic [23:0]        rgb_o,
  output logic               pixel_on_o,
  output logic               alive_o,
  output logic               killed_o,
  output logic [3:0]         health_o
);

  // Sprite-local coordinate widths: UW holds 0..SIZE-1, SW leaves headroom
  // for the octagon distance sum; XW holds a relative offset plus SIZE/2
  // without wrapping.
  localparam int UW   = $clog2(SIZE);
  localparam int SW   = UW + 2;
  localparam int XW   = COORD_W + 2;
  localparam int HALF = SIZE / 2;
  localparam int Q    = SIZE / 4;

  localparam logic [SW-1:0] C_HALF    = SW'(HALF);
  localparam logic [SW-1:0] C_HALFM1  = SW'(HALF - 1);
  localparam logic [SW-1:0] C_HALFP1  = SW'(HALF + 1);
  localparam logic [SW-1:0] C_Q       = SW'(Q);
  localparam logic [SW-1:0] C_Q3      = SW'(3 * Q);
  localparam logic [SW-1:0] C_Q1      = SW'(Q + 1);
  localparam logic [SW-1:0] C_Q3M1    = SW'(3 * Q - 1);
  localparam logic [SW-1:0] C_LAST    = SW'(SIZE - 1);
  localparam logic [SW-1:0] C_SIZEM2  = SW'(SIZE - 2);
  localparam logic [XW-1:0] C_HALF_X  = XW'(HALF);
  localparam logic [XW-1:0] C_SIZE_X  = XW'(SIZE);
  localparam logic [3:0]    C_FLASH   = 4'(FLASH_FRAMES);
  localparam logic [3:0]    C_EXPLODE = 4'(EXPLODE_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ALIVE   = 2'd1,
    S_FLASH   = 2'd2,
    S_EXPLODE = 2'd3
  } state_t;

  state_t      state_q;
  logic [1:0]  type_q;
  logic [3:0]  health_q;
  logic [3:0]  anim_q;
  logic        par_q;
  logic        killed_q;
  logic [23:0] rgb_q;
  logic        pixel_on_q;

  // Spawn health lookup by type.
  function automatic logic [3:0] hp_of(input logic [1:0] t);
    case (t)
      2'd0:    hp_of = 4'(HP_T0);
      2'd1:    hp_of = 4'(HP_T1);
      2'd2:    hp_of = 4'(HP_T2);
      default: hp_of = 4'(HP_T3);
    endcase
  endfunction

  // Life-cycle FSM: spawn wins over everything, hits only land in ALIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      type_q   <= 2'd0;
      health_q <= 4'd0;
      anim_q   <= 4'd0;
      par_q    <= 1'b0;
      killed_q <= 1'b0;
    end else begin
      killed_q <= 1'b0;
      if (spawn_i) begin
        state_q  <= S_ALIVE;
        type_q   <= spawn_type_i;
        health_q <= hp_of(spawn_type_i);
        anim_q   <= 4'd0;
      end else begin
        case (state_q)
          S_ALIVE: begin
            // A tick in the same cycle as a hit is deliberately dropped.
            if (hit_i) begin
              if (health_q == 4'd1) begin
                health_q <= 4'd0;
                state_q  <= S_EXPLODE;
                anim_q   <= C_EXPLODE;
                par_q    <= 1'b0;
                killed_q <= 1'b1;
              end else begin
                health_q <= health_q - 4'd1;
                state_q  <= S_FLASH;
                anim_q   <= C_FLASH;
              end
            end
          end
          S_FLASH: begin
            if (frame_tick_i) begin
              anim_q <= anim_q - 4'd1;
              if (anim_q == 4'd1) state_q <= S_ALIVE;
            end
          end
          S_EXPLODE: begin
            if (frame_tick_i) begin
              anim_q <= anim_q - 4'd1;
              par_q  <= ~par_q;
              if (anim_q == 4'd1) state_q <= S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Relative position, widened so that far-apart points never alias into
  // the window.
  logic [XW-1:0] w_xs;
  logic [XW-1:0] w_ys;
  logic          w_in_win;
  logic [UW-1:0] w_u;
  logic [UW-1:0] w_v;
  logic [SW-1:0] w_ue;
  logic [SW-1:0] w_ve;
  logic [SW-1:0] w_cu;
  logic [SW-1:0] w_dv;

  assign w_xs     = {2'b00, hcount_i} - {2'b00, x_mid_i} + C_HALF_X;
  assign w_ys     = {2'b00, vcount_i} - {2'b00, y_mid_i} + C_HALF_X;
  assign w_in_win = !w_xs[XW-1] && (w_xs < C_SIZE_X) &&
                    !w_ys[XW-1] && (w_ys < C_SIZE_X);
  assign w_u      = w_xs[UW-1:0];
  assign w_v      = w_ys[UW-1:0];
  assign w_ue     = {2'b00, w_u};
  assign w_ve     = {2'b00, w_v};
  // Octagon: horizontal distance from the centre column pair, vertical
  // distance from row SIZE/2-1.
  assign w_cu     = (w_ue < C_HALF) ? (C_HALFM1 - w_ue) : (w_ue - C_HALF);
  assign w_dv     = (w_ve >= C_HALFM1) ? (w_ve - C_HALFM1) : (C_HALFM1 - w_ve);

  logic w_shape;

  // Shape mask for the current type inside the sprite square.
  always_comb begin
    w_shape = 1'b0;
    case (type_q)
      2'd0: w_shape = 1'b1;
      2'd1: w_shape = ((w_ue >= C_Q) && (w_ue < C_Q3)) ||
                      ((w_ve >= C_Q1) && (w_ve < C_Q3M1));
      2'd2: w_shape = (w_ve <= C_SIZEM2) && ((w_cu + w_dv) <= C_HALFP1);
      default: w_shape = (w_ue == '0) || (w_ue == C_LAST) ||
                         (w_ve == '0) || (w_ve == C_LAST);
    endcase
  end

  logic [23:0] w_rgb;
  logic        w_on;

  // Colour selection from the pre-update state and health.
  always_comb begin
    w_rgb = 24'h000000;
    w_on  = 1'b0;
    if (w_in_win && w_shape) begin
      case (state_q)
        S_FLASH: begin
          w_rgb = 24'h00FFFF;
          w_on  = 1'b1;
        end
        S_EXPLODE: begin
          if ((w_u[0] ^ w_v[0] ^ par_q) == 1'b0) begin
            w_rgb = 24'hFF8000;
            w_on  = 1'b1;
          end
        end
        S_ALIVE: begin
          w_on = 1'b1;
          if (type_q == 2'd0)           w_rgb = 24'hFF0000;
          else if (health_q >= 4'd4)    w_rgb = 24'hFFFFFF;
          else if (health_q == 4'd3)    w_rgb = 24'hFF00FF;
          else if (health_q == 4'd2)    w_rgb = 24'hFFF000;
          else                          w_rgb = 24'hFF0000;
        end
        default: ;
      endcase
    end
  end

  // One-cycle registered pixel output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q      <= 24'h000000;
      pixel_on_q <= 1'b0;
    end else begin
      rgb_q      <= w_rgb;
      pixel_on_q <= w_on;
    end
  end

  assign rgb_o      = rgb_q;
  assign pixel_on_o = pixel_on_q;
  assign killed_o   = killed_q;
  assign health_o   = health_q;
  assign alive_o    = (state_q == S_ALIVE) || (state_q == S_FLASH);

endmodule
`default_nettype wire

// File: tb/tb_enemy_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_enemy_sprite_engine
// Description : Directed bench for enemy_sprite_engine. Drives a 16-pixel and
//               a 32-pixel instance with identical stimulus and checks both
//               every cycle against a behavioural model, plus hand-computed
//               literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_sprite_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       spawn = 1'b0;
  logic [1:0] stype = 2'd0;
  logic       hit = 1'b0;
  logic       tick = 1'b0;
  logic [9:0] xm = 10'd100;
  logic [9:0] ym = 10'd100;
  logic [9:0] hc = 10'd0;
  logic [9:0] vc = 10'd0;

  logic [23:0] rgb16, rgb32;
  logic        on16, on32, alive16, alive32, killed16, killed32;
  logic [3:0]  hp16, hp32;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  enemy_sprite_engine #(.SIZE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .spawn_i(spawn), .spawn_type_i(stype),
    .hit_i(hit), .frame_tick_i(tick), .x_mid_i(xm), .y_mid_i(ym),
    .hcount_i(hc), .vcount_i(vc), .rgb_o(rgb16), .pixel_on_o(on16),
    .alive_o(alive16), .killed_o(killed16), .health_o(hp16));

  enemy_sprite_engine #(.SIZE(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .spawn_i(spawn), .spawn_type_i(stype),
    .hit_i(hit), .frame_tick_i(tick), .x_mid_i(xm), .y_mid_i(ym),
    .hcount_i(hc), .vcount_i(vc), .rgb_o(rgb32), .pixel_on_o(on32),
    .alive_o(alive32), .killed_o(killed32), .health_o(hp32));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_ALIVE = 1, M_FLASH = 2, M_EXPL = 3;
  int m_st = M_IDLE, m_type = 0, m_hp = 0, m_cnt = 0, m_par = 0;
  bit m_killed = 1'b0;
  logic [24:0] e16 = '0, e32 = '0;
  int hp_tab [4] = '{1, 4, 3, 2};

  // Returns {pixel_on, rgb} for a sprite of edge 'size'.
  function automatic logic [24:0] mpix(int size, int h_c, int v_c, int x_m, int y_m,
                                       int st, int ty, int hpv, int par);
    int h, q, xr, yr, u, v, cu, dv;
    bit on;
    h = size / 2; q = size / 4;
    xr = h_c - x_m; yr = v_c - y_m;
    if (xr < -h || xr >= h || yr < -h || yr >= h) return '0;
    u = xr + h; v = yr + h;
    case (ty)
      0: on = 1'b1;
      1: on = (u >= q && u < 3*q) || (v >= q+1 && v < 3*q-1);
      2: begin
        cu = (u < h) ? (h - 1 - u) : (u - h);
        dv = v - (h - 1);
        if (dv < 0) dv = -dv;
        on = (v <= size - 2) && (cu + dv <= h + 1);
      end
      default: on = (u == 0) || (u == size-1) || (v == 0) || (v == size-1);
    endcase
    if (!on) return '0;
    case (st)
      M_FLASH: return {1'b1, 24'h00FFFF};
      M_EXPL:  return (((u ^ v ^ par) & 1) == 0) ? {1'b1, 24'hFF8000} : 25'd0;
      M_ALIVE: begin
        if (ty == 0)     return {1'b1, 24'hFF0000};
        if (hpv >= 4)    return {1'b1, 24'hFFFFFF};
        if (hpv == 3)    return {1'b1, 24'hFF00FF};
        if (hpv == 2)    return {1'b1, 24'hFFF000};
        return {1'b1, 24'hFF0000};
      end
      default: return '0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = M_IDLE; m_type = 0; m_hp = 0; m_cnt = 0; m_par = 0;
      m_killed = 1'b0; e16 = '0; e32 = '0;
    end else begin
      e16 = mpix(16, int'(hc), int'(vc), int'(xm), int'(ym), m_st, m_type, m_hp, m_par);
      e32 = mpix(32, int'(hc), int'(vc), int'(xm), int'(ym), m_st, m_type, m_hp, m_par);
      m_killed = 1'b0;
      if (spawn) begin
        m_st = M_ALIVE; m_type = int'(stype); m_hp = hp_tab[stype]; m_cnt = 0;
      end else if (m_st == M_ALIVE && hit) begin
        if (m_hp == 1) begin
          m_hp = 0; m_st = M_EXPL; m_cnt = 8; m_par = 0; m_killed = 1'b1;
        end else begin
          m_hp = m_hp - 1; m_st = M_FLASH; m_cnt = 4;
        end
      end else if (m_st == M_FLASH && tick) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_st = M_ALIVE;
      end else if (m_st == M_EXPL && tick) begin
        m_cnt = m_cnt - 1;
        m_par = m_par ^ 1;
        if (m_cnt == 0) m_st = M_IDLE;
      end
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pix16", {7'd0, on16, rgb16}, {7'd0, e16});
      chk("pix32", {7'd0, on32, rgb32}, {7'd0, e32});
      chk("ctl16", {26'd0, alive16, killed16, hp16},
          {26'd0, (m_st == M_ALIVE || m_st == M_FLASH), m_killed, 4'(m_hp)});
      chk("ctl32", {26'd0, alive32, killed32, hp32},
          {26'd0, (m_st == M_ALIVE || m_st == M_FLASH), m_killed, 4'(m_hp)});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_spawn(input logic [1:0] t);
    spawn = 1'b1; stype = t; step(); spawn = 1'b0;
  endtask

  task automatic do_hit();
    hit = 1'b1; step(); hit = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; step(); tick = 1'b0; step();
  endtask

  task automatic scan(input int h, input int v);
    hc = 10'(h); vc = 10'(v); step();
  endtask

  task automatic sweep();
    for (int dy = -18; dy < 18; dy++)
      for (int dx = -18; dx < 18; dx++)
        scan(int'(xm) + dx, int'(ym) + dy);
    hc = 10'd100; vc = 10'd100;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_rgb", rgb16, 24'h0);
    chk("rst_on", on16, 1'b0);
    chk("rst_hp", hp16, 4'd0);
    chk("rst_alive", alive16, 1'b0);
    chk("rst_killed", killed16, 1'b0);

    // type1 spawn and cross geometry
    do_spawn(2'd1);
    chk("t1_hp", hp16, 4'd4);
    chk("t1_alive", alive16, 1'b1);
    scan(92, 95);
    chk("t1_off", on16, 1'b0);
    scan(92, 100);
    chk("t1_on", on16, 1'b1);
    chk("t1_rgb", rgb16, 24'hFFFFFF);
    sweep();

    // hit, flash, invulnerability
    hc = 10'd100; vc = 10'd100;
    do_hit();
    chk("hit_hp", hp16, 4'd3);
    step();
    chk("flash_rgb", rgb16, 24'h00FFFF);
    do_hit();
    chk("inv_hp", hp16, 4'd3);
    do_tick(); do_tick(); do_tick();
    chk("flash3_rgb", rgb16, 24'h00FFFF);
    sweep();
    do_tick();
    chk("hp3_rgb", rgb16, 24'hFF00FF);

    // hit and tick together: full flash length
    hit = 1'b1; tick = 1'b1; step(); hit = 1'b0; tick = 1'b0;
    chk("ht_hp", hp16, 4'd2);
    do_tick(); do_tick(); do_tick();
    chk("ht_flash", rgb16, 24'h00FFFF);
    do_tick();
    chk("ht_alive", rgb16, 24'hFFF000);

    // kill and explosion
    do_spawn(2'd0);
    do_hit();
    chk("kill_pulse", killed16, 1'b1);
    chk("kill_hp", hp16, 4'd0);
    chk("kill_alive", alive16, 1'b0);
    step();
    chk("kill_once", killed16, 1'b0);
    chk("expl_rgb0", rgb16, 24'hFF8000);
    sweep();
    do_tick();
    chk("expl_inv", on16, 1'b0);
    scan(101, 100);
    chk("expl_inv2", rgb16, 24'hFF8000);
    for (int i = 0; i < 6; i++) do_tick();
    chk("expl_last", rgb16, 24'hFF8000);
    do_tick();
    chk("expl_idle", on16, 1'b0);

    // spawn + hit same cycle: spawn wins
    do_spawn(2'd0);
    spawn = 1'b1; stype = 2'd3; hit = 1'b1; step(); spawn = 1'b0; hit = 1'b0;
    chk("sp_hit_kill", killed16, 1'b0);
    chk("sp_hit_hp", hp16, 4'd2);
    chk("sp_hit_alive", alive16, 1'b1);

    // no wrap in window test
    xm = 10'd3; hc = 10'd1020; vc = 10'd100; step();
    chk("nowrap_a", on16, 1'b0);
    xm = 10'd1020; hc = 10'd3; step();
    chk("nowrap_b", on16, 1'b0);
    hc = 10'd1012; step();
    chk("edge_rgb", rgb16, 24'hFFF000);
    xm = 10'd100;

    // octagon bottom row never on
    do_spawn(2'd2);
    scan(100, 107);
    chk("oct_bot", on16, 1'b0);
    scan(100, 106);
    chk("oct_on", rgb16, 24'hFF00FF);
    sweep();

    // hollow square on both sizes
    do_spawn(2'd3);
    sweep();

    // spawn aborts explosion
    do_spawn(2'd0);
    do_hit();
    do_tick();
    do_spawn(2'd3);
    chk("abort_kill", killed16, 1'b0);
    chk("abort_hp", hp16, 4'd2);
    chk("abort_alive", alive16, 1'b1);

    // reset mid-flash
    do_spawn(2'd1);
    do_hit();
    rst_n = 1'b0; step();
    chk("rf_rgb", rgb16, 24'h0);
    chk("rf_on", on16, 1'b0);
    chk("rf_hp", hp16, 4'd0);
    chk("rf_alive", alive16, 1'b0);
    rst_n = 1'b1;
    do_hit();
    chk("rf_hit_hp", hp16, 4'd0);
    chk("rf_hit_alive", alive16, 1'b0);
    step();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
